// File: rtl/hw_sw_mailbox.sv
// Software-to-hardware register mailbox: software fills shadow registers over
// Avalon-MM and requests a commit; all shadows are published to hw_data
// together on the next frame_sync, so the hardware never sees a half-update.
//
// state | meaning
// IDLE  | no commit pending; hw_data holds the last published set
// ARMED | commit requested; shadows are copied on the next frame_sync
module hw_sw_mailbox #(
  parameter int NUM_CH = 10,
  parameter int DATA_W = 32,
  parameter int SIG_W  = 2,
  parameter int ADDR_W = 5
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [ADDR_W-1:0]        avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [DATA_W-1:0]        avs_writedata,
  output logic [DATA_W-1:0]        avs_readdata,
  input  logic                     frame_sync,
  input  logic [SIG_W-1:0]         hw_sig_in,
  output logic [SIG_W-1:0]         sw_sig_out,
  output logic [NUM_CH*DATA_W-1:0] hw_data,
  output logic                     hw_update
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] A_HW_SIG = ADDR_W'(NUM_CH + 1);
  localparam logic [ADDR_W-1:0] A_FCNT   = ADDR_W'(NUM_CH + 2);

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [NUM_CH*DATA_W-1:0]  shadow_q;
  logic [SIG_W-1:0]          hw_sig_q;
  logic [DATA_W-1:0]         frame_cnt_q;
  logic [DATA_W-1:0]         rd_data;
  logic                      ctrl_wr, commit_req, abort_req, copy_now;
  logic                      unused_wdata;

  // Only CTRL bits 0, 1 and the signal field carry meaning on writes to CTRL.
  assign unused_wdata = ^avs_writedata;

  assign ctrl_wr    = avs_write && (avs_address == A_CTRL);
  assign abort_req  = ctrl_wr && avs_writedata[1];
  assign commit_req = ctrl_wr && avs_writedata[0] && !avs_writedata[1];

  // Commit FSM: abort always beats both commit and a coincident frame_sync.
  always_comb begin
    state_d  = state_q;
    copy_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req) state_d = ARMED;
      end
      ARMED: begin
        if (abort_req) begin
          state_d = IDLE;
        end else if (frame_sync) begin
          state_d  = IDLE;
          copy_now = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Shadow writes; a write in the copy cycle lands after the copy reads the old value.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      shadow_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (avs_write && (avs_address == ADDR_W'(k)))
          shadow_q[k*DATA_W +: DATA_W] <= avs_writedata;
      end
    end
  end

  // Atomic publish of every shadow plus the one-cycle update strobe.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hw_data   <= '0;
      hw_update <= 1'b0;
    end else begin
      hw_update <= copy_now;
      if (copy_now) hw_data <= shadow_q;
    end
  end

  // Signal bits, hardware status capture and frame counter.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_sig_out  <= '0;
      hw_sig_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      hw_sig_q <= hw_sig_in;
      if (ctrl_wr)    sw_sig_out  <= avs_writedata[8 +: SIG_W];
      if (frame_sync) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  // Read decode; unmapped addresses return zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (avs_address == ADDR_W'(k)) rd_data = shadow_q[k*DATA_W +: DATA_W];
    end
    if (avs_address == A_CTRL) begin
      rd_data[0]          = (state_q == ARMED);
      rd_data[8 +: SIG_W] = sw_sig_out;
    end
    if (avs_address == A_HW_SIG) rd_data[SIG_W-1:0] = hw_sig_q;
    if (avs_address == A_FCNT)   rd_data = frame_cnt_q;
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  avs_readdata <= '0;
    else if (avs_read)   avs_readdata <= rd_data;
  end

endmodule

// File: tb/tb_hw_sw_mailbox.sv
module tb_hw_sw_mailbox;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    address = '0;
  logic          rd = 1'b0, wr = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          fs = 1'b0;
  logic [1:0]    sig_in = '0;
  logic [1:0]    sig_out;
  logic [319:0]  hw_data;
  logic          hw_update;

  // small instance used only for the frame counter wrap
  logic [1:0]    s_address = '0;
  logic          s_rd = 1'b0;
  logic          s_fs = 1'b0;
  logic [9:0]    s_rdata;
  logic [1:0]    s_sig_out;
  logic [9:0]    s_hw_data;
  logic          s_hw_update;

  int errors = 0;
  int checks = 0;
  logic [31:0] r;
  logic        upd_seen;

  always #5 clk = ~clk;

  hw_sw_mailbox dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(address), .avs_read(rd), .avs_write(wr),
    .avs_writedata(wdata), .avs_readdata(rdata),
    .frame_sync(fs), .hw_sig_in(sig_in), .sw_sig_out(sig_out),
    .hw_data(hw_data), .hw_update(hw_update)
  );

  hw_sw_mailbox #(.NUM_CH(1), .DATA_W(10), .SIG_W(2), .ADDR_W(2)) dut_small (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(s_address), .avs_read(s_rd), .avs_write(1'b0),
    .avs_writedata(10'd0), .avs_readdata(s_rdata),
    .frame_sync(s_fs), .hw_sig_in(2'b00), .sw_sig_out(s_sig_out),
    .hw_data(s_hw_data), .hw_update(s_hw_update)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ch(input int k);
    return hw_data[k*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    address = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    address = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_hw_data_zero", {31'd0, |hw_data}, 32'd0);
    chk("rst_hw_update", {31'd0, hw_update}, 32'd0);
    chk("rst_sig_out", {30'd0, sig_out}, 32'd0);
    chk("rst_readdata", rdata, 32'd0);

    // atomic commit
    bus_wr(5'd0, 32'hDEADBEEF);
    bus_wr(5'd9, 32'h12345678);
    bus_wr(5'd10, 32'h1);
    tick();
    chk("armed_ch0_unchanged", ch(0), 32'd0);
    bus_rd(5'd10, r);
    chk("pending_set", r, 32'h1);
    bus_rd(5'd0, r);
    chk("shadow0_read", r, 32'hDEADBEEF);
    pulse_fs();
    chk("commit_ch0", ch(0), 32'hDEADBEEF);
    chk("commit_ch9", ch(9), 32'h12345678);
    chk("commit_update_hi", {31'd0, hw_update}, 32'd1);
    tick();
    chk("commit_update_one_cycle", {31'd0, hw_update}, 32'd0);
    bus_rd(5'd10, r);
    chk("pending_clear", r, 32'h0);

    // commit coincident with frame_sync: no copy on that edge
    bus_wr(5'd0, 32'h11111111);
    address = 5'd10; wdata = 32'h1; wr = 1'b1; fs = 1'b1;
    tick();
    wr = 1'b0; fs = 1'b0;
    chk("commit_fs_no_update", {31'd0, hw_update}, 32'd0);
    chk("commit_fs_ch0_old", ch(0), 32'hDEADBEEF);
    bus_rd(5'd10, r);
    chk("commit_fs_pending", r, 32'h1);

    // shadow write in the copy cycle
    address = 5'd3; wdata = 32'hAA; wr = 1'b1; fs = 1'b1;
    tick();
    wr = 1'b0; fs = 1'b0;
    chk("copy_ch0_new", ch(0), 32'h11111111);
    chk("copy_update", {31'd0, hw_update}, 32'd1);
    chk("copy_ch3_pre_write", ch(3), 32'h0);
    bus_rd(5'd3, r);
    chk("shadow3_kept", r, 32'hAA);

    // abort before frame_sync
    bus_wr(5'd10, 32'h1);
    bus_wr(5'd10, 32'h2);
    bus_rd(5'd10, r);
    chk("abort_pending_clear", r, 32'h0);
    upd_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_fs();
      upd_seen = upd_seen | hw_update;
      tick();
      upd_seen = upd_seen | hw_update;
    end
    chk("abort_no_update", {31'd0, upd_seen}, 32'd0);
    chk("abort_ch3_unchanged", ch(3), 32'h0);

    // commit+abort in one write from IDLE
    bus_wr(5'd10, 32'h3);
    bus_rd(5'd10, r);
    chk("ctrl3_stays_idle", r, 32'h0);
    pulse_fs();
    chk("ctrl3_no_update", {31'd0, hw_update}, 32'd0);

    // abort coincident with frame_sync while armed
    bus_wr(5'd10, 32'h1);
    address = 5'd10; wdata = 32'h2; wr = 1'b1; fs = 1'b1;
    tick();
    wr = 1'b0; fs = 1'b0;
    chk("abort_fs_no_update", {31'd0, hw_update}, 32'd0);
    chk("abort_fs_ch3", ch(3), 32'h0);

    // repeated commit is idempotent
    bus_wr(5'd10, 32'h1);
    bus_wr(5'd10, 32'h1);
    bus_rd(5'd10, r);
    chk("recommit_pending", r, 32'h1);
    pulse_fs();
    chk("recommit_ch3", ch(3), 32'hAA);
    chk("recommit_update", {31'd0, hw_update}, 32'd1);

    // signal register and hardware status
    bus_wr(5'd10, 32'h200);
    chk("sw_sig_out", {30'd0, sig_out}, 32'h2);
    bus_rd(5'd10, r);
    chk("ctrl_read_sig", r, 32'h200);
    sig_in = 2'b01;
    tick();
    bus_rd(5'd11, r);
    chk("hw_sig_read", r, 32'h1);

    // mid-ARMED reset
    bus_wr(5'd10, 32'h1);
    rst_n = 1'b0;
    #2;
    chk("midrst_hw_data", {31'd0, |hw_data}, 32'd0);
    chk("midrst_hw_update", {31'd0, hw_update}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus_rd(5'd10, r);
    chk("midrst_pending", r, 32'h0);
    bus_rd(5'd12, r);
    chk("midrst_fcnt", r, 32'h0);
    bus_rd(5'd3, r);
    chk("midrst_shadow3", r, 32'h0);

    // frame counter
    for (int i = 0; i < 5; i++) begin
      pulse_fs();
      tick();
    end
    bus_wr(5'd12, 32'h1234);
    bus_rd(5'd12, r);
    chk("fcnt_five_ro", r, 32'h5);
    address = 5'd0;
    tick();
    chk("readdata_held", rdata, 32'h5);

    // unmapped reads
    bus_rd(5'd13, r);
    chk("unmapped_13", r, 32'h0);
    bus_wr(5'd31, 32'hFFFF_FFFF);
    bus_rd(5'd31, r);
    chk("unmapped_31", r, 32'h0);

    // counter wrap on the 10-bit instance
    s_fs = 1'b1;
    repeat (1023) tick();
    s_fs = 1'b0;
    s_address = 2'd3; s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    chk("fcnt_all_ones", {22'd0, s_rdata}, 32'h3FF);
    s_fs = 1'b1;
    tick();
    s_fs = 1'b0;
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    chk("fcnt_wrap", {22'd0, s_rdata}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hw_sw_mailbox.md
Name: hw_sw_mailbox

Overview:
Parametrised software-to-hardware register mailbox that replaces fixed banks of 32-bit PIO export ports and 2-bit signal ports. The Nios side writes NUM_CH shadow registers over an Avalon-MM slave, then requests a commit. The block copies all shadows to the active hardware-facing outputs atomically on the next frame_sync pulse, so game-state updates are tear-free. It also provides a software-driven signal register, a readable hardware status input and a frame counter.

Parameters:
NUM_CH, 10, number of data channels (1..16)
DATA_W, 32, width of each channel and of the Avalon data bus; must be >= 8+SIG_W
SIG_W, 2, width of the sw_sig_out and hw_sig_in signal buses
ADDR_W, 5, Avalon word-address width; 2^ADDR_W >= NUM_CH+3 required

Ports:
clk_clk  in  1  system clock; all logic on the rising edge
reset_reset_n  in  1  asynchronous active-low reset
avs_address  in  ADDR_W  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  DATA_W  write data
avs_readdata  out  DATA_W  read data, registered
frame_sync  in  1  one-cycle frame-boundary pulse, synchronous to clk_clk
hw_sig_in  in  SIG_W  hardware status toward software
sw_sig_out  out  SIG_W  software-controlled signal bits toward hardware
hw_data  out  NUM_CH*DATA_W  active channel data; channel k occupies bits [k*DATA_W +: DATA_W]
hw_update  out  1  one-cycle pulse when hw_data has just changed by commit

Behaviour:
- Clocking and reset: one clock, clk_clk. reset_reset_n is asynchronous and active-low.
- On reset, all of the following are 0: shadows, hw_data, sw_sig_out, avs_readdata, hw_update, frame counter, hw_sig register. The FSM goes to IDLE.
- Register map (word addresses):
  - 0..NUM_CH-1 SHADOW[k], RW.
  - NUM_CH CTRL:
    - Write: bit0 COMMIT, bit1 ABORT, bits [8+SIG_W-1:8] load sw_sig_out.
    - Read: bit0 PENDING (state==ARMED), bits [8+SIG_W-1:8] sw_sig_out, other bits 0.
  - NUM_CH+1 HW_SIG, RO: registered hw_sig_in, zero-extended.
  - NUM_CH+2 FRAME_CNT, RO.
  - Unmapped addresses: reads return 0, writes are ignored. Writes to RO registers are ignored.
- Read latency is 1 cycle: avs_readdata is updated on the edge where avs_read=1 and holds its value otherwise. No waitrequest.
- sw_sig_out updates on the CTRL write edge and is visible the next cycle, independent of the FSM.
- hw_sig_in is registered once. HW_SIG returns the value as of the edge before the read.
- FRAME_CNT increments on every frame_sync. It wraps from 2^DATA_W-1 to 0.
- FSM states:
  - IDLE: a CTRL write with COMMIT=1 and ABORT=0 goes to ARMED.
  - ARMED, on frame_sync=1: hw_data <= all shadows; hw_update <= 1 for exactly one cycle, coincident with the first cycle of new hw_data; go to IDLE.
  - ARMED, on a CTRL write with ABORT=1: go to IDLE, no copy.
  - ARMED, on COMMIT again: stays ARMED (idempotent).
- Simultaneous events:
  - COMMIT write in the same cycle as frame_sync while IDLE: goes to ARMED; the copy waits for the next frame_sync.
  - ABORT and frame_sync in the same cycle while ARMED: ABORT wins; no copy, no hw_update.
  - COMMIT=1 and ABORT=1 in one write: ABORT wins.
  - SHADOW write in the copy cycle: hw_data takes the pre-write shadow value; the new value stays in the shadow for the next commit.
  - SHADOW writes while ARMED are allowed; the last write before the copy edge is published.
- hw_data changes only on the copy edge or reset. Shadows are never cleared by commit.
- Mid-operation reset returns to IDLE with zeroed outputs; a pending commit is lost.

Test Plan:
- Reset: assert reset_reset_n=0 mid-ARMED -> hw_data=0, hw_update=0, PENDING reads 0, FRAME_CNT=0.
- Atomic commit: write SHADOW[0]=0xDEADBEEF and SHADOW[9]=0x12345678, then CTRL=1 -> hw_data unchanged until frame_sync. On the edge after frame_sync, channels 0 and 9 equal the written values and hw_update is high for exactly 1 cycle. PENDING then reads 0.
- Simultaneous events:
  - COMMIT in the same cycle as frame_sync -> no copy on that edge; copy on the following frame_sync.
  - SHADOW[3]=0xAA written in the copy cycle -> hw_data ch3 keeps its old value, SHADOW[3] reads 0xAA.
- Abort: CTRL=1, then CTRL=2 before frame_sync -> no hw_update over 3 frame_syncs, hw_data unchanged. CTRL=3 from IDLE -> stays IDLE.
- Signals and counter:
  - CTRL write with bits[9:8]=2'b10 -> sw_sig_out=2'b10 next cycle.
  - hw_sig_in=2'b01 -> HW_SIG reads 1.
  - 5 frame_sync pulses -> FRAME_CNT=5.
  - Preloaded FRAME_CNT at all-ones plus one pulse -> 0.
- Bus edge cases: read address NUM_CH+3 -> 0; write to FRAME_CNT has no effect; every read returns data 1 cycle after avs_read.
